// File: rtl/branch_predict_unit_if.sv
// Branch unit bus: IF-stage prediction lookup, EX-stage resolve inputs, flush/redirect and counters.
// master = pipeline side driving fetch/EX operands, slave = branch_predict_unit.
interface branch_predict_unit_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
);
   logic [XLEN-1:0]  if_pc;
   logic             if_pred_taken;
   logic             ex_valid;
   logic             ex_branch;
   logic [2:0]       ex_func3;
   logic [XLEN-1:0]  ex_rs1;
   logic [XLEN-1:0]  ex_rs2;
   logic [XLEN-1:0]  ex_pc;
   logic [XLEN-1:0]  ex_target;
   logic             ex_pred_taken;
   logic             ex_taken;
   logic             ex_illegal;
   logic             flush;
   logic [XLEN-1:0]  redirect_pc;
   logic [CNT_W-1:0] branch_cnt;
   logic [CNT_W-1:0] mispredict_cnt;

   modport master (
      output if_pc, ex_valid, ex_branch, ex_func3, ex_rs1, ex_rs2, ex_pc, ex_target, ex_pred_taken,
      input  if_pred_taken, ex_taken, ex_illegal, flush, redirect_pc, branch_cnt, mispredict_cnt
   );

   modport slave (
      input  if_pc, ex_valid, ex_branch, ex_func3, ex_rs1, ex_rs2, ex_pc, ex_target, ex_pred_taken,
      output if_pred_taken, ex_taken, ex_illegal, flush, redirect_pc, branch_cnt, mispredict_cnt
   );
endinterface

// File: rtl/branch_predict_unit.sv
// RV32I branch resolve + 2-bit saturating-counter predictor; predict/resolve combinational,
// training, flush/redirect and perf counters registered one cycle later. No backpressure.
module branch_predict_unit #(
   parameter int XLEN        = 32,
   parameter int BHT_ENTRIES = 64,
   parameter int CNT_W       = 32
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   branch_predict_unit_if.slave bp
);
   localparam int IDX_W = $clog2(BHT_ENTRIES);

   logic [1:0]       r_bht [BHT_ENTRIES];
   logic             r_flush;
   logic [XLEN-1:0]  r_redirect_pc;
   logic [CNT_W-1:0] r_branch_cnt;
   logic [CNT_W-1:0] r_mispredict_cnt;

   logic [IDX_W-1:0] w_if_idx;
   logic [IDX_W-1:0] w_ex_idx;
   logic             w_branch;
   logic             w_illegal;
   logic             w_cond;
   logic             w_taken;
   logic             w_resolve;
   logic             w_mispredict;
   logic [1:0]       w_cur;
   logic [1:0]       w_next;
   logic             w_unused;

   assign w_if_idx = bp.if_pc[IDX_W+1:2];
   assign w_ex_idx = bp.ex_pc[IDX_W+1:2];
   assign w_unused = ^{bp.if_pc[XLEN-1:IDX_W+2], bp.if_pc[1:0]};

   // Read port shows the pre-update counter when IF and EX hit the same entry.
   assign bp.if_pred_taken = r_bht[w_if_idx][1];

   always_comb begin
      w_cond = 1'b0;
      case (bp.ex_func3)
         3'b000:  w_cond = (bp.ex_rs1 == bp.ex_rs2);
         3'b001:  w_cond = (bp.ex_rs1 != bp.ex_rs2);
         3'b100:  w_cond = ($signed(bp.ex_rs1) <  $signed(bp.ex_rs2));
         3'b101:  w_cond = ($signed(bp.ex_rs1) >= $signed(bp.ex_rs2));
         3'b110:  w_cond = (bp.ex_rs1 <  bp.ex_rs2);
         3'b111:  w_cond = (bp.ex_rs1 >= bp.ex_rs2);
         default: w_cond = 1'b0;
      endcase
   end

   assign w_branch     = bp.ex_valid & bp.ex_branch;
   assign w_illegal    = w_branch & (bp.ex_func3[2:1] == 2'b01);
   assign w_resolve    = w_branch & ~w_illegal;
   assign w_taken      = w_resolve & w_cond;
   assign w_mispredict = w_resolve & (w_taken != bp.ex_pred_taken);

   assign bp.ex_taken   = w_taken;
   assign bp.ex_illegal = w_illegal;

   assign w_cur = r_bht[w_ex_idx];

   always_comb begin
      w_next = w_cur;
      if (w_taken) begin
         if (w_cur != 2'b11) w_next = w_cur + 2'b01;
      end else begin
         if (w_cur != 2'b00) w_next = w_cur - 2'b01;
      end
   end

   // Reset wins over any resolve in the same cycle, so a pending mispredict is dropped.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= 2'b01;
         r_flush          <= 1'b0;
         r_redirect_pc    <= '0;
         r_branch_cnt     <= '0;
         r_mispredict_cnt <= '0;
      end else begin
         r_flush <= w_mispredict;
         if (w_resolve) begin
            r_bht[w_ex_idx] <= w_next;
            r_branch_cnt    <= r_branch_cnt + CNT_W'(1);
         end
         if (w_mispredict) begin
            r_redirect_pc    <= w_taken ? bp.ex_target : (bp.ex_pc + XLEN'(4));
            r_mispredict_cnt <= r_mispredict_cnt + CNT_W'(1);
         end
      end
   end

   assign bp.flush          = r_flush;
   assign bp.redirect_pc    = r_redirect_pc;
   assign bp.branch_cnt     = r_branch_cnt;
   assign bp.mispredict_cnt = r_mispredict_cnt;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios plus randomized traffic
// against a behavioural model of the counter table, flush/redirect and counters.
module tb_branch_predict_unit;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   branch_predict_unit_if #(.XLEN(32), .CNT_W(32)) bp ();

   branch_predict_unit #(.XLEN(32), .BHT_ENTRIES(64), .CNT_W(32)) dut (
      .i_clk   (clk),
      .i_reset (reset),
      .bp      (bp)
   );

   int checks = 0;
   int errors = 0;

   // Reference state: predictor counters as plain integers 0..3
   int          m_ctr [64];
   bit          m_flush;
   bit [31:0]   m_redir;
   bit [31:0]   m_bcnt;
   bit [31:0]   m_mcnt;

   function automatic bit ref_cond(input bit [2:0] f, input bit [31:0] a, input bit [31:0] b);
      int sa, sb;
      sa = int'(a);
      sb = int'(b);
      case (f)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd4:    return sa < sb;
         3'd5:    return sa >= sb;
         3'd6:    return a < b;
         3'd7:    return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   function automatic int idx_of(input bit [31:0] pc);
      return int'(pc[7:2]);
   endfunction

   function automatic bit exp_illegal();
      return bp.ex_valid && bp.ex_branch && (bp.ex_func3 == 3'd2 || bp.ex_func3 == 3'd3);
   endfunction

   function automatic bit exp_taken();
      if (!(bp.ex_valid && bp.ex_branch) || exp_illegal()) return 1'b0;
      return ref_cond(bp.ex_func3, bp.ex_rs1, bp.ex_rs2);
   endfunction

   function automatic bit exp_pred();
      return m_ctr[idx_of(bp.if_pc)] >= 2;
   endfunction

   task automatic drive(input bit v, input bit br, input bit [2:0] f, input bit [31:0] a,
                        input bit [31:0] b, input bit [31:0] pc, input bit [31:0] tgt,
                        input bit pred, input bit [31:0] ifpc);
      bp.ex_valid      = v;
      bp.ex_branch     = br;
      bp.ex_func3      = f;
      bp.ex_rs1        = a;
      bp.ex_rs2        = b;
      bp.ex_pc         = pc;
      bp.ex_target     = tgt;
      bp.ex_pred_taken = pred;
      bp.if_pc         = ifpc;
   endtask

   // Advances the model by one clock using the currently driven inputs, then the DUT.
   task automatic tick(input bit rst);
      bit legal, t;
      int i;
      reset = rst;
      if (rst) begin
         for (int k = 0; k < 64; k++) m_ctr[k] = 1;
         m_flush = 0; m_redir = 0; m_bcnt = 0; m_mcnt = 0;
      end else begin
         legal = bp.ex_valid && bp.ex_branch && !exp_illegal();
         t = exp_taken();
         m_flush = 0;
         if (legal) begin
            i = idx_of(bp.ex_pc);
            m_ctr[i] = t ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1) : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
            m_bcnt++;
            if (t != bp.ex_pred_taken) begin
               m_flush = 1;
               m_redir = t ? bp.ex_target : bp.ex_pc + 32'd4;
               m_mcnt++;
            end
         end
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h100);
      tick(1);
      #1;
      checks++; if (bp.if_pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred_0x100 got %0b want 0", bp.if_pred_taken); end
      checks++; if (bp.flush !== 1'b0 || bp.redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_flush got %0b/%h want 0/0", bp.flush, bp.redirect_pc); end
      checks++; if (bp.branch_cnt !== 32'd0 || bp.mispredict_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", bp.branch_cnt, bp.mispredict_cnt); end
      for (int i = 0; i < 64; i++) begin
         bp.if_pc = 32'h100 + 32'(i) * 4;
         #1;
         checks++; if (bp.if_pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred idx %0d got %0b want 0", i, bp.if_pred_taken); end
      end
      tick(0);
   endtask

   task automatic test_compare();
      bit [2:0]  f   [6] = '{3'd4, 3'd6, 3'd0, 3'd1, 3'd5, 3'd7};
      bit [31:0] a   [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd5, 32'd5, 32'd5};
      bit [31:0] b   [6] = '{32'd1, 32'd1, 32'd5, 32'd5, 32'd5, 32'd5};
      bit        exp [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      for (int k = 0; k < 6; k++) begin
         drive(1, 1, f[k], a[k], b[k], 32'h300, 32'h400, exp[k], 32'h0);
         #1;
         checks++; if (bp.ex_taken !== exp[k]) begin errors++; $display("FAIL cmp func3=%0d got %0b want %0b", f[k], bp.ex_taken, exp[k]); end
         tick(0);
      end
      drive(0, 1, 3'd0, 32'd5, 32'd5, 32'h300, 32'h400, 0, 32'h0);
      #1;
      checks++; if (bp.ex_taken !== 1'b0) begin errors++; $display("FAIL cmp_invalid got %0b want 0", bp.ex_taken); end
      tick(0);
   endtask

   task automatic test_training();
      bit pred   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      bit fl     [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      bit ifpred [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(1);
      for (int k = 0; k < 4; k++) begin
         drive(1, 1, 3'd0, 32'd7, 32'd7, 32'h40, 32'h200, pred[k], 32'h40);
         #1;
         checks++; if (bp.if_pred_taken !== ifpred[k]) begin errors++; $display("FAIL train_pred #%0d got %0b want %0b", k, bp.if_pred_taken, ifpred[k]); end
         tick(0);
         checks++; if (bp.flush !== fl[k]) begin errors++; $display("FAIL train_flush #%0d got %0b want %0b", k, bp.flush, fl[k]); end
         checks++; if (bp.redirect_pc !== 32'h200) begin errors++; $display("FAIL train_redirect #%0d got %h want 00000200", k, bp.redirect_pc); end
      end
      checks++; if (bp.branch_cnt !== 32'd4 || bp.mispredict_cnt !== 32'd2) begin errors++; $display("FAIL train_cnt got %0d/%0d want 4/2", bp.branch_cnt, bp.mispredict_cnt); end
   endtask

   task automatic test_wrap_redirect();
      drive(1, 1, 3'd0, 32'd1, 32'd2, 32'hFFFF_FFFC, 32'h1234, 1, 32'h0);
      tick(0);
      checks++; if (bp.flush !== 1'b1 || bp.redirect_pc !== 32'h0) begin errors++; $display("FAIL wrap got %0b/%h want 1/00000000", bp.flush, bp.redirect_pc); end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(0);
      checks++; if (bp.flush !== 1'b0) begin errors++; $display("FAIL wrap_pulse got %0b want 0", bp.flush); end
   endtask

   task automatic test_illegal();
      bit [31:0] bc, mc;
      bc = m_bcnt; mc = m_mcnt;
      for (int k = 2; k < 4; k++) begin
         drive(1, 1, 3'(k), 32'd3, 32'd3, 32'h40, 32'h500, 1, 32'h40);
         #1;
         checks++; if (bp.ex_illegal !== 1'b1 || bp.ex_taken !== 1'b0) begin errors++; $display("FAIL illegal func3=%0d got %0b/%0b want 1/0", k, bp.ex_illegal, bp.ex_taken); end
         tick(0);
         checks++; if (bp.flush !== 1'b0) begin errors++; $display("FAIL illegal_flush got %0b want 0", bp.flush); end
      end
      checks++; if (bp.branch_cnt !== bc || bp.mispredict_cnt !== mc) begin errors++; $display("FAIL illegal_cnt got %0d/%0d want %0d/%0d", bp.branch_cnt, bp.mispredict_cnt, bc, mc); end
   endtask

   task automatic test_back_to_back();
      drive(1, 1, 3'd1, 32'd1, 32'd2, 32'h10, 32'h800, 0, 32'h0);
      tick(0);
      checks++; if (bp.flush !== 1'b1 || bp.redirect_pc !== 32'h800) begin errors++; $display("FAIL b2b_first got %0b/%h want 1/00000800", bp.flush, bp.redirect_pc); end
      drive(1, 1, 3'd6, 32'd9, 32'd2, 32'h20, 32'h900, 1, 32'h0);
      tick(0);
      checks++; if (bp.flush !== 1'b1 || bp.redirect_pc !== 32'h24) begin errors++; $display("FAIL b2b_second got %0b/%h want 1/00000024", bp.flush, bp.redirect_pc); end
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 2; k++) begin
         drive(1, 1, 3'd0, 32'd1, 32'd1, 32'h80, 32'h600, 1, 32'h80);
         tick(0);
      end
      drive(1, 1, 3'd0, 32'd1, 32'd1, 32'h80, 32'h600, 0, 32'h80);
      tick(1);
      checks++; if (bp.flush !== 1'b0 || bp.redirect_pc !== 32'h0) begin errors++; $display("FAIL midrst_flush got %0b/%h want 0/0", bp.flush, bp.redirect_pc); end
      checks++; if (bp.branch_cnt !== 32'd0 || bp.mispredict_cnt !== 32'd0) begin errors++; $display("FAIL midrst_cnt got %0d/%0d want 0/0", bp.branch_cnt, bp.mispredict_cnt); end
      drive(1, 1, 3'd0, 32'd1, 32'd1, 32'h80, 32'h600, 0, 32'h80);
      #1;
      checks++; if (bp.if_pred_taken !== 1'b0) begin errors++; $display("FAIL midrst_pred got %0b want 0", bp.if_pred_taken); end
      tick(0);
      #1;
      checks++; if (bp.if_pred_taken !== 1'b1) begin errors++; $display("FAIL midrst_entry01 got %0b want 1", bp.if_pred_taken); end
   endtask

   task automatic test_random();
      bit rst;
      for (int n = 0; n < 600; n++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
               ($urandom_range(0, 3) == 0) ? 32'd5 : $urandom, ($urandom_range(0, 3) == 0) ? 32'd5 : $urandom,
               {24'h0, 6'($urandom_range(0, 7)), 2'b00} | (($urandom_range(0, 7) == 0) ? 32'hFFFF_FF00 : 32'h0),
               $urandom, 1'($urandom), {24'h0, 6'($urandom_range(0, 7)), 2'($urandom)});
         if ($urandom_range(0, 3) == 0) bp.ex_pc = $urandom;
         bp.ex_rs1[31] = ($urandom_range(0, 1) == 0) ? 1'b1 : bp.ex_rs1[31];
         #1;
         checks++; if (bp.if_pred_taken !== exp_pred()) begin errors++; $display("FAIL rnd_pred n=%0d got %0b want %0b", n, bp.if_pred_taken, exp_pred()); end
         checks++; if (bp.ex_taken !== exp_taken()) begin errors++; $display("FAIL rnd_taken n=%0d got %0b want %0b", n, bp.ex_taken, exp_taken()); end
         checks++; if (bp.ex_illegal !== exp_illegal()) begin errors++; $display("FAIL rnd_illegal n=%0d got %0b want %0b", n, bp.ex_illegal, exp_illegal()); end
         rst = ($urandom_range(0, 59) == 0);
         tick(rst);
         checks++; if (bp.flush !== m_flush || bp.redirect_pc !== m_redir) begin errors++; $display("FAIL rnd_flush n=%0d got %0b/%h want %0b/%h", n, bp.flush, bp.redirect_pc, m_flush, m_redir); end
         checks++; if (bp.branch_cnt !== m_bcnt || bp.mispredict_cnt !== m_mcnt) begin errors++; $display("FAIL rnd_cnt n=%0d got %0d/%0d want %0d/%0d", n, bp.branch_cnt, bp.mispredict_cnt, m_bcnt, m_mcnt); end
      end
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      test_reset();
      test_compare();
      test_training();
      test_wrap_redirect();
      test_illegal();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
